pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_renderer.sv | 154 +++++++++++++++
 tb/tb_pong_renderer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_renderer.sv
// Pong frame renderer: per-pixel hit tests against per-frame shadowed object positions,
// followed by registered colour selection with a HIT-triggered flash of the ball and border.
module pong_renderer #(
    parameter int unsigned COORD_W      = 11,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 50,
    parameter int unsigned BALL_SIZE    = 10,
    parameter int unsigned PADDLE1X     = 20,
    parameter int unsigned PADDLE2X     = 610,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic               VGA_CLOCK,
    input  logic               RESET_N,
    input  logic [COORD_W-1:0] XPOS,
    input  logic [COORD_W-1:0] YPOS,
    input  logic               DISP_EN,
    input  logic               FRAME_START,
    input  logic [COORD_W-1:0] PADDLE1Y,
    input  logic [COORD_W-1:0] PADDLE2Y,
    input  logic [COORD_W-1:0] BALLX,
    input  logic [COORD_W-1:0] BALLY,
    input  logic               HIT,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               DISP_EN_OUT
);

    localparam int unsigned FlashW = (FLASH_FRAMES < 2) ? 1 : $clog2(FLASH_FRAMES + 1);

    localparam logic [COORD_W-1:0] Paddle1X  = COORD_W'(PADDLE1X);
    localparam logic [COORD_W-1:0] Paddle2X  = COORD_W'(PADDLE2X);
    localparam logic [COORD_W-1:0] XLast     = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] YLast     = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W:0]   PaddleWEx = (COORD_W + 1)'(PADDLE_W);
    localparam logic [COORD_W:0]   PaddleHEx = (COORD_W + 1)'(PADDLE_H);
    localparam logic [COORD_W:0]   BallEx    = (COORD_W + 1)'(BALL_SIZE);
    localparam logic [FlashW-1:0]  FlashLoad = FlashW'(FLASH_FRAMES);
    localparam logic [COLOR_W-1:0] Ones      = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] Zero      = '0;

    // Half-open span test with one extra bit so origin+size never wraps to the left edge.
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] origin,
                                     input logic [COORD_W:0]   size);
        logic [COORD_W:0] p;
        logic [COORD_W:0] lo;
        logic [COORD_W:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, origin};
        hi = lo + size;
        return (p >= lo) && (p < hi);
    endfunction

    logic [COORD_W-1:0] p1y_q, p2y_q, bx_q, by_q;
    logic [FlashW-1:0]  flash_q, flash_d;

    logic hit_p1_d, hit_p2_d, hit_ball_d, border_d;
    logic hit_p1_q, hit_p2_q, hit_ball_q, border_q, de1_q;

    logic [COLOR_W-1:0] r_d, g_d, b_d;

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            p1y_q <= '0;
            p2y_q <= '0;
            bx_q  <= '0;
            by_q  <= '0;
        end else if (FRAME_START) begin
            p1y_q <= PADDLE1Y;
            p2y_q <= PADDLE2Y;
            bx_q  <= BALLX;
            by_q  <= BALLY;
        end
    end

    always_comb begin
        flash_d = flash_q;
        if (HIT) begin
            flash_d = FlashLoad;
        end else if (FRAME_START && (flash_q != '0)) begin
            flash_d = flash_q - 1'b1;
        end
    end

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end

    always_comb begin
        hit_p1_d   = in_span(XPOS, Paddle1X, PaddleWEx) && in_span(YPOS, p1y_q, PaddleHEx);
        hit_p2_d   = in_span(XPOS, Paddle2X, PaddleWEx) && in_span(YPOS, p2y_q, PaddleHEx);
        hit_ball_d = in_span(XPOS, bx_q, BallEx) && in_span(YPOS, by_q, BallEx);
        border_d   = (XPOS == '0) || (XPOS == XLast) || (YPOS == '0) || (YPOS == YLast);
    end

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_p1_q   <= 1'b0;
            hit_p2_q   <= 1'b0;
            hit_ball_q <= 1'b0;
            border_q   <= 1'b0;
            de1_q      <= 1'b0;
        end else begin
            hit_p1_q   <= hit_p1_d;
            hit_p2_q   <= hit_p2_d;
            hit_ball_q <= hit_ball_d;
            border_q   <= border_d;
            de1_q      <= DISP_EN;
        end
    end

    // Paddles outrank ball/border, so they stay white even while flashing.
    always_comb begin
        r_d = Zero;
        g_d = Zero;
        b_d = Zero;
        if (de1_q) begin
            if (hit_p1_q || hit_p2_q) begin
                r_d = Ones;
                g_d = Ones;
                b_d = Ones;
            end else if (hit_ball_q || border_q) begin
                r_d = Ones;
                g_d = (flash_q != '0) ? Zero : Ones;
                b_d = (flash_q != '0) ? Zero : Ones;
            end else begin
                b_d = Ones;
            end
        end
    end

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            R           <= Zero;
            G           <= Zero;
            B           <= Zero;
            DISP_EN_OUT <= 1'b0;
        end else begin
            R           <= r_d;
            G           <= g_d;
            B           <= b_d;
            DISP_EN_OUT <= de1_q;
        end
    end

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: table of pixel vectors plus sequences for
// shadowing, flash counting, asynchronous reset and coordinate wrap.
module tb_pong_renderer;

    localparam logic [12:0] White = 13'h1FFF;
    localparam logic [12:0] Bg    = 13'h100F;
    localparam logic [12:0] Red   = 13'h1F00;
    localparam logic [12:0] Off   = 13'h0000;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic [12:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [10:0] xpos, ypos;
    logic        disp_en, frame_start, hit;
    logic [10:0] p1y, p2y, bx, by;
    logic [3:0]  r, g, b;
    logic        de_out;

    int checks   = 0;
    int failures = 0;

    pong_renderer dut (
        .VGA_CLOCK   (clk),
        .RESET_N     (rst_n),
        .XPOS        (xpos),
        .YPOS        (ypos),
        .DISP_EN     (disp_en),
        .FRAME_START (frame_start),
        .PADDLE1Y    (p1y),
        .PADDLE2Y    (p2y),
        .BALLX       (bx),
        .BALLY       (by),
        .HIT         (hit),
        .R           (r),
        .G           (g),
        .B           (b),
        .DISP_EN_OUT (de_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int x, input int y, input logic de, input logic [12:0] e,
                                input string n);
        vec_t v;
        v.x    = 11'(x);
        v.y    = 11'(y);
        v.de   = de;
        v.exp  = e;
        v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {de_out, r, g, b};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got de/rgb=%h expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic pix(input int x, input int y, input logic de);
        xpos    = 11'(x);
        ypos    = 11'(y);
        disp_en = de;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int a, input int c, input int d, input int e, input logic h);
        p1y         = 11'(a);
        p2y         = 11'(c);
        bx          = 11'(d);
        by          = 11'(e);
        frame_start = 1'b1;
        hit         = h;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        hit         = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(posedge clk);
        #1;
        hit = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(20, 100, 1'b1, White, "p1 top-left"));
        vecs.push_back(mk(30, 100, 1'b1, Bg, "p1 right edge excluded"));
        vecs.push_back(mk(20, 150, 1'b1, Bg, "p1 bottom edge excluded"));
        vecs.push_back(mk(29, 149, 1'b1, White, "p1 bottom-right"));
        vecs.push_back(mk(19, 120, 1'b1, Bg, "left of p1"));
        vecs.push_back(mk(610, 200, 1'b1, White, "p2 top-left"));
        vecs.push_back(mk(619, 249, 1'b1, White, "p2 bottom-right"));
        vecs.push_back(mk(620, 200, 1'b1, Bg, "right of p2"));
        vecs.push_back(mk(305, 245, 1'b1, White, "ball inside"));
        vecs.push_back(mk(310, 245, 1'b1, Bg, "ball right excluded"));
        vecs.push_back(mk(300, 239, 1'b1, Bg, "above ball"));
        vecs.push_back(mk(0, 240, 1'b1, White, "border left"));
        vecs.push_back(mk(639, 10, 1'b1, White, "border right"));
        vecs.push_back(mk(100, 0, 1'b1, White, "border top"));
        vecs.push_back(mk(100, 479, 1'b1, White, "border bottom"));
        vecs.push_back(mk(640, 10, 1'b1, Bg, "x=640 not border"));
        vecs.push_back(mk(20, 100, 1'b0, Off, "blanked on paddle"));
        vecs.push_back(mk(100, 100, 1'b1, Bg, "background"));
        vecs.push_back(mk(0, 0, 1'b0, Off, "blanked on border"));

        rst_n       = 1'b0;
        xpos        = 11'd20;
        ypos        = 11'd0;
        disp_en     = 1'b1;
        frame_start = 1'b0;
        hit         = 1'b0;
        p1y         = 11'd0;
        p2y         = 11'd0;
        bx          = 11'd0;
        by          = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", Off);
        rst_n = 1'b1;

        frame(100, 200, 300, 240, 1'b0);
        foreach (vecs[i]) begin
            pix(vecs[i].x, vecs[i].y, vecs[i].de);
            check(vecs[i].name, vecs[i].exp);
        end

        // Two-cycle latency: one edge after the change the old pixel is still shown.
        pix(50, 50, 1'b1);
        xpos = 11'd20;
        ypos = 11'd100;
        @(posedge clk);
        #1;
        check("latency n+1 still old", Bg);
        @(posedge clk);
        #1;
        check("latency n+2 new", White);

        // Position change without FRAME_START must not show.
        bx = 11'd400;
        pix(305, 245, 1'b1);
        check("ball old pos held", White);
        pix(405, 245, 1'b1);
        check("ball new pos hidden", Bg);
        frame(100, 200, 400, 240, 1'b0);
        pix(405, 245, 1'b1);
        check("ball new pos after frame", White);
        pix(305, 245, 1'b1);
        check("ball old pos gone", Bg);

        // Flash and priority: ball overlaps paddle1.
        frame(100, 200, 18, 100, 1'b0);
        pix(18, 105, 1'b1);
        check("ball white no flash", White);
        pulse_hit();
        pix(22, 105, 1'b1);
        check("paddle over ball in flash", White);
        pix(18, 105, 1'b1);
        check("ball red in flash", Red);
        pix(639, 10, 1'b1);
        check("border red in flash", Red);
        pix(50, 50, 1'b1);
        check("background in flash", Bg);
        pix(615, 210, 1'b1);
        check("p2 white in flash", White);
        pix(639, 10, 1'b1);
        for (int k = 1; k <= 7; k++) frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("flash after 7 frames", Red);
        frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("flash ends after 8 frames", White);
        frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("flash saturates at 0", White);

        // HIT coincident with FRAME_START loads the full count.
        frame(100, 200, 18, 100, 1'b1);
        for (int k = 1; k <= 7; k++) frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("coincident hit 7 frames", Red);
        frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("coincident hit 8 frames", White);

        // Retrigger while flashing.
        pulse_hit();
        for (int k = 1; k <= 3; k++) frame(100, 200, 18, 100, 1'b0);
        pulse_hit();
        for (int k = 1; k <= 7; k++) frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("retrigger 7 frames", Red);
        frame(100, 200, 18, 100, 1'b0);
        pix(639, 10, 1'b1);
        check("retrigger 8 frames", White);

        // Asynchronous reset mid-line while flashing and drawing.
        frame(100, 200, 300, 240, 1'b0);
        pulse_hit();
        pix(20, 100, 1'b1);
        check("pre-reset paddle", White);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset clears outputs", Off);
        @(posedge clk);
        #1;
        check("reset held", Off);
        rst_n = 1'b1;
        pix(20, 100, 1'b1);
        check("no paddle after reset", Bg);
        pix(305, 245, 1'b1);
        check("no ball after reset", Bg);
        pix(639, 10, 1'b1);
        check("flash cleared by reset", White);
        frame(100, 200, 300, 240, 1'b0);
        pix(20, 100, 1'b1);
        check("paddle after first frame", White);

        // Ball near the top of the coordinate range must not wrap to x=0..4.
        frame(300, 300, 2043, 100, 1'b0);
        pix(1, 105, 1'b1);
        check("no wrap x=1", Bg);
        pix(4, 105, 1'b1);
        check("no wrap x=4", Bg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
